// File: rtl/rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// rr_hold_arbiter
//
// Registered round-robin arbiter with grant hold. A winner keeps the shared
// resource while it keeps requesting, for at most MAX_HOLD consecutive
// cycles. The grant then passes to the next requester in circular order,
// starting just after the previous owner. A switch between owners happens on
// a single edge, with no idle cycle in between.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   req_i        [N-1:0] request vector, bit i belongs to requester i
//   gnt_o        [N-1:0] one-hot grant, all-zero when there is no owner
//   gnt_valid_o  high while an owner holds the grant
//   gnt_idx_o    binary index of the owner, 0 when gnt_valid_o is low
//   gnt_new_o    one-cycle pulse in the first cycle of every grant
//
// Every output is decoded from registered state only, so there is no
// combinational path from req_i to any output.
// ---------------------------------------------------------------------------
module rr_hold_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_new_o
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            gnt_new_q, gnt_new_d;

  logic [IW-1:0]   owner_inc;
  logic            release_grant;
  logic [IW:0]     hit_idle;   // {found, index} for a search from ptr_q
  logic [IW:0]     hit_rel;    // {found, index} for a search from owner+1

  // Circular first-set-bit search starting at s. The loop runs from the far
  // end back towards s so that the closest set bit is the last assignment
  // and therefore wins.
  function automatic logic [IW:0] search(input logic [N-1:0] v,
                                         input logic [IW-1:0] s);
    logic [IW:0] res;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(s) + k;
      if (idx >= N) idx = idx - N;
      if (v[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  assign owner_inc     = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
  assign release_grant = !req_i[owner_q] || (hold_cnt_q == CW'(MAX_HOLD - 1));
  assign hit_idle      = search(req_i, ptr_q);
  // Searching from owner+1 naturally visits the old owner last, so a
  // still-requesting owner at hold expiry only wins when it is alone.
  assign hit_rel       = search(req_i, owner_inc);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gnt_new_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_idle[IW]) begin
          state_d    = GRANT;
          owner_d    = hit_idle[IW-1:0];
          hold_cnt_d = '0;
          gnt_new_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!release_grant) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end else begin
          ptr_d      = owner_inc;
          hold_cnt_d = '0;
          if (hit_rel[IW]) begin
            owner_d   = hit_rel[IW-1:0];
            gnt_new_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      gnt_new_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_new_q  <= gnt_new_d;
    end
  end

  assign gnt_valid_o = (state_q == GRANT);
  assign gnt_idx_o   = gnt_valid_o ? owner_q : '0;
  assign gnt_new_o   = gnt_new_q;

  // One-hot decode of the registered owner.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt_o[gi] = gnt_valid_o && (owner_q == IW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_hold_arbiter
//
// Scoreboard bench for rr_hold_arbiter (N=8, MAX_HOLD=4). The stimulus
// process drives req/rst_n just after each rising edge, advances a
// behavioural model of the arbitration rules for the edge that will sample
// those values, and queues the expected outputs tagged with that edge
// number. A separate monitor samples the DUT on every falling edge, pops the
// matching entry and compares, and also checks the global invariants
// (one-hot grant, tenure bound, wait bound).
// ---------------------------------------------------------------------------
module tb_rr_hold_arbiter;

  localparam int N  = 8;
  localparam int MH = 4;
  localparam int WAIT_MAX = (N - 1) * MH + 1;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_idx;
  logic         gnt_new;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx),
    .gnt_new_o  (gnt_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // number of rising edges seen so far

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] gnt;
    logic         valid;
    logic [2:0]   idx;
    logic         nw;
  } exp_t;

  exp_t sb_q[$];

  // ---------------- behavioural reference model ----------------
  // busy/owner/tenure describe who holds the resource and for how many
  // cycles so far; ptr is where the next search from idle begins.
  bit m_busy;
  int m_owner, m_ptr, m_ten;

  function automatic int find_first(logic [N-1:0] r, int start);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_ten = 0;
  endtask

  // Advance the model by one edge that samples (r, rn) and queue the
  // outputs visible after that edge.
  task automatic model_step(input logic [N-1:0] r, input logic rn);
    exp_t e;
    int   w;
    bit   fresh;
    fresh = 0;
    if (!rn) begin
      model_reset();
    end else if (!m_busy) begin
      w = find_first(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_ten = 1; fresh = 1;
      end
    end else if (r[m_owner] && m_ten < MH) begin
      m_ten++;
    end else begin
      m_ptr = (m_owner + 1) % N;
      w = find_first(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ten = 1; fresh = 1;
      end else begin
        m_busy = 0;
      end
    end
    e.cyc   = cyc + 1;
    e.valid = m_busy;
    e.gnt   = m_busy ? N'(1) << m_owner : '0;
    e.idx   = m_busy ? 3'(m_owner) : 3'd0;
    e.nw    = fresh;
    sb_q.push_back(e);
  endtask

  // One transaction: wait for an edge, then drive the values the following
  // edge will sample.
  task automatic drive(input logic [N-1:0] r, input logic rn);
    @(posedge clk);
    #1;
    req   = r;
    rst_n = rn;
    model_step(r, rn);
  endtask

  // Pull reset between edges (after the falling-edge sample) and check that
  // the grant disappears without waiting for a clock.
  task automatic async_reset_mid();
    exp_t e;
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || gnt_valid !== 1'b0 || gnt_new !== 1'b0) begin
      errors++;
      $display("FAIL async_reset gnt=%h valid=%b new=%b expected gnt=00 valid=0 new=0",
               gnt, gnt_valid, gnt_new);
    end
    model_reset();
    e.cyc = cyc + 1; e.gnt = '0; e.valid = 0; e.idx = 0; e.nw = 0;
    sb_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  int   mon_ten = 0;
  int   wait_cnt[N];

  initial for (int i = 0; i < N; i++) wait_cnt[i] = 0;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL stale_entry edge=%0d now=%0d", mon_e.cyc, cyc);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (gnt !== mon_e.gnt || gnt_valid !== mon_e.valid ||
          gnt_idx !== mon_e.idx || gnt_new !== mon_e.nw) begin
        errors++;
        $display("FAIL outputs edge=%0d req=%h got gnt=%h valid=%b idx=%0d new=%b expected gnt=%h valid=%b idx=%0d new=%b",
                 cyc, req, gnt, gnt_valid, gnt_idx, gnt_new,
                 mon_e.gnt, mon_e.valid, mon_e.idx, mon_e.nw);
      end
    end

    // one-hot or zero, and valid consistent with gnt
    checks++;
    if (!(gnt == '0 || $onehot(gnt)) || (gnt_valid !== (gnt != '0))) begin
      errors++;
      $display("FAIL onehot edge=%0d gnt=%h valid=%b", cyc, gnt, gnt_valid);
    end

    // tenure of the current grant
    if (!gnt_valid)    mon_ten = 0;
    else if (gnt_new)  mon_ten = 1;
    else               mon_ten++;
    checks++;
    if (mon_ten > MH) begin
      errors++;
      $display("FAIL tenure edge=%0d owner=%0d got %0d cycles limit %0d",
               cyc, gnt_idx, mon_ten, MH);
    end

    // wait bound for every requester
    for (int i = 0; i < N; i++) begin
      if (!rst_n || !req[i] || gnt[i]) wait_cnt[i] = 0;
      else wait_cnt[i]++;
      if (wait_cnt[i] > WAIT_MAX) begin
        checks++;
        errors++;
        $display("FAIL wait edge=%0d requester=%0d got %0d cycles limit %0d",
                 cyc, i, wait_cnt[i], WAIT_MAX);
        wait_cnt[i] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] r;
    exp_t e0;

    // reset held with all requests active
    rst_n = 1'b0;
    req   = 8'hFF;
    model_reset();
    e0.cyc = 1; e0.gnt = '0; e0.valid = 0; e0.idx = 0; e0.nw = 0;
    sb_q.push_back(e0);
    repeat (3) drive(8'hFF, 1'b0);
    repeat (4) drive(8'hFF, 1'b1);     // first edge grants requester 0

    // hold limit with a single requester
    repeat (3) drive(8'h00, 1'b1);
    repeat (12) drive(8'h01, 1'b1);

    // rotation between two requesters
    repeat (2) drive(8'h00, 1'b1);
    repeat (14) drive(8'h09, 1'b1);

    // early release: owner drops, then the next owner drops
    repeat (2) drive(8'h00, 1'b1);
    repeat (3) drive(8'h0C, 1'b1);
    repeat (2) drive(8'h08, 1'b1);
    repeat (2) drive(8'h00, 1'b1);

    // wrap-around from owner 7
    repeat (5) drive(8'h80, 1'b1);
    repeat (6) drive(8'h81, 1'b1);
    repeat (2) drive(8'h00, 1'b1);

    // sticky random requests
    r = 8'(($urandom));
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      drive(r, 1'b1);
    end

    // fully random requests
    for (int i = 0; i < 300; i++) drive(8'($urandom), 1'b1);

    // reset in the middle of a grant, then restart with 8'h90
    repeat (6) drive(8'hFF, 1'b1);
    async_reset_mid();
    repeat (2) drive(8'hFF, 1'b0);
    repeat (4) drive(8'h90, 1'b1);
    repeat (2) drive(8'h00, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Registered round-robin arbiter with grant hold, sharing one resource among N requesters. A winner keeps its grant while it holds its request, up to a bounded burst of MAX_HOLD cycles. The grant then rotates to the next requester in circular order. It is the sequential companion to the combinational fixed-priority arbiter in the ARBITERS library, and it is used wherever starvation-free, burst-friendly access is required.

## Interface
- N, 8, number of requesters; legal range N >= 2
- MAX_HOLD, 16, maximum consecutive cycles one owner holds a grant; legal range MAX_HOLD >= 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector; bit i is requester i
- gnt  output  N  registered one-hot grant, or all-zero when no owner
- gnt_valid  output  1  high when gnt is non-zero
- gnt_idx  output  $clog2(N)  binary index of the current owner; 0 when gnt_valid=0
- gnt_new  output  1  one-cycle pulse in the first cycle of every grant, including a re-grant to the same owner

## Operation
- State: IDLE (no owner) or GRANT (owner registered).
- Internal registers:
  - ptr: round-robin start index.
  - owner: current owner index.
  - hold_cnt: width $clog2(MAX_HOLD+1).
- search(v, s): returns the first set bit of v scanning s, s+1, …, N-1, 0, …, s-1, or none.
- IDLE transitions:
  - If req != 0: take w = search(req, ptr), go to GRANT, set owner = w, hold_cnt = 0, gnt_new = 1.
  - Otherwise stay in IDLE.
- GRANT release condition: req[owner] == 0, or hold_cnt == MAX_HOLD-1.
- No release: keep owner, hold_cnt += 1, gnt_new = 0.
- On release:
  - Set ptr = (owner+1) mod N, then evaluate w = search(req, (owner+1) mod N).
  - If w exists: switch to w with no idle gap, hold_cnt = 0, gnt_new = 1.
  - If none: go to IDLE with gnt = 0.
  - If the owner still requests at hold expiry, it is searched last. It is re-granted only when it is the sole requester.
- Requests from non-owners never pre-empt an owner before release.
- Any req bits may change on any cycle; only values sampled at the clock edge matter.
- All outputs are derived from registers only; there is no combinational path from req to the outputs.

## Timing
- Reset values (asynchronous, immediate on rst_n low): gnt=0, gnt_valid=0, gnt_idx=0, gnt_new=0, ptr=0, owner=0, hold_cnt=0, state=IDLE.
- The first edge after rst_n rises samples req normally.
- Grant latency: req asserted before edge k, with the arbiter IDLE, gives gnt at edge k, visible in cycle k+1.
- Maximum tenure: exactly MAX_HOLD consecutive cycles with gnt high for one grant.
- Owner drop: req[owner] low sampled at edge k moves gnt to the next owner, or to 0, at edge k. Gnt therefore overlaps the first low-req cycle by one cycle.
- Worst-case wait for a continuously requesting bit: (N-1)·MAX_HOLD cycles plus 1 latency cycle.
- MAX_HOLD=1: grant rotates every cycle, and gnt_new is high every cycle while any request is present.
- Wrap-around: owner N-1 releases to a search starting at index 0.
- Reset mid-grant: gnt drops asynchronously, and ptr returns to 0.

## Test plan
- Reset: req=8'hFF held with rst_n=0 → all outputs 0. After rst_n rises, first edge → gnt=8'h01, gnt_idx=0, gnt_new=1.
- Hold limit (N=8, MAX_HOLD=4): req=8'h01 for 12 cycles → gnt=8'h01 continuously, with gnt_new pulsing every 4 cycles.
- Rotation: req=8'h09 constant → gnt sequence 01×4, 08×4, 01×4, with no zero cycles between grants.
- Early release: req=8'h0C, owner 2 granted; drop bit 2 after 2 grant cycles → next edge gnt=8'h08, gnt_new=1. Bit 3 then drops → gnt=0, gnt_valid=0.
- Wrap: owner 7 with req=8'h81 at hold expiry → gnt=8'h01. Random req stress with a checker confirming:
  - gnt is one-hot or zero;
  - tenure is at most MAX_HOLD;
  - no requester waits more than (N-1)·MAX_HOLD+1 cycles.
- Async reset mid-grant: rst_n pulled low between edges → gnt=0 immediately. After release with req=8'h90 → gnt=8'h10.
